// File: rtl/t05_tree_walker_pkg.sv
// Shared Huffman types: node word layout, child encoding, walker state encoding.
package t05_huff_pkg;
   localparam int unsigned IDX_W  = 7;
   localparam int unsigned NODE_W = 71;

   localparam logic [8:0] CHILD_NULL = 9'b110000000;

   typedef struct packed {
      logic [6:0]  idx;
      logic [8:0]  left;
      logic [8:0]  right;
      logic [45:0] sum;
   } node_t;

   typedef enum logic [1:0] {
      KIND_LEAF,
      KIND_NODE,
      KIND_NULL
   } child_kind_e;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_WAIT_BIT = 3'd2,
      ST_EMIT     = 3'd3,
      ST_ERROR    = 3'd4
   } state_e;

   function automatic child_kind_e child_kind(input logic [8:0] c);
      if (c == CHILD_NULL) return KIND_NULL;
      else if (c[8])       return KIND_NODE;
      else                 return KIND_LEAF;
   endfunction
endpackage

// File: rtl/t05_tree_walker_if.sv
// Bit stream, SRAM read port and character output of the Huffman walker.
interface t05_tree_walker_if;
   logic                              dec_en;
   logic [t05_huff_pkg::IDX_W-1:0]    root_idx;
   logic                              bit_in;
   logic                              bit_valid;
   logic                              bit_ready;
   logic [t05_huff_pkg::IDX_W-1:0]    rd_addr;
   logic                              rd_req;
   logic                              WorR;
   logic [t05_huff_pkg::NODE_W-1:0]   rd_data;
   logic                              SRAM_finished;
   logic [7:0]                        char_out;
   logic                              char_valid;
   logic                              err;
   logic [2:0]                        state_reg;

   modport master (
      input  dec_en, root_idx, bit_in, bit_valid, rd_data, SRAM_finished,
      output bit_ready, rd_addr, rd_req, WorR, char_out, char_valid, err, state_reg
   );

   modport slave (
      output dec_en, root_idx, bit_in, bit_valid, rd_data, SRAM_finished,
      input  bit_ready, rd_addr, rd_req, WorR, char_out, char_valid, err, state_reg
   );
endinterface

// File: rtl/t05_tree_walker.sv
// Huffman decode walker: fetches nodes from SRAM, follows one bit per edge, emits leaf chars.
// Optional root-node cache enabled by defining T05_ROOT_CACHE_EN.
module t05_tree_walker
   import t05_huff_pkg::*;
#(
   parameter int unsigned MAX_DEPTH = 127
)(
   input  logic               clk,
   input  logic               rst_n,
   t05_tree_walker_if.master  bus
);
   localparam logic [7:0] MAX_D = 8'(MAX_DEPTH);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] cur_addr_q, cur_addr_d;
   logic [6:0]       depth_q, depth_d;
   node_t            node_q, node_d;
   logic [7:0]       char_q, char_d;
   logic             bit_ready_q, rd_req_q, char_valid_q, err_q;
   logic [IDX_W-1:0] rd_addr_q;
   logic [8:0]       child;
   node_t            rd_node;
   logic             unused_node;

   assign rd_node     = node_t'(bus.rd_data);
   assign child       = bus.bit_in ? node_q.right : node_q.left;
   assign unused_node = ^{node_q.idx, node_q.sum};

`ifdef T05_ROOT_CACHE_EN
   node_t root_q;
   logic  root_vld_q;
   logic  cache_wr;
`endif

   always_comb begin
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      depth_d    = depth_q;
      node_d     = node_q;
      char_d     = char_q;
`ifdef T05_ROOT_CACHE_EN
      cache_wr   = 1'b0;
`endif
      if (!bus.dec_en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cur_addr_d = bus.root_idx;
               depth_d    = '0;
               state_d    = ST_FETCH;
            end
            ST_FETCH: begin
               if (bus.SRAM_finished) begin
                  node_d = rd_node;
                  if (rd_node.idx != cur_addr_q) begin
                     state_d = ST_ERROR;
                  end else begin
                     state_d = ST_WAIT_BIT;
`ifdef T05_ROOT_CACHE_EN
                     cache_wr = (depth_q == '0);
`endif
                  end
               end
            end
            ST_WAIT_BIT: begin
               if (bus.bit_valid) begin
                  case (child_kind(child))
                     KIND_NULL: state_d = ST_ERROR;
                     KIND_LEAF: begin
                        char_d  = child[7:0];
                        state_d = ST_EMIT;
                     end
                     default: begin
                        if (({1'b0, depth_q} + 8'd1) > MAX_D) begin
                           state_d = ST_ERROR;
                        end else begin
                           cur_addr_d = child[6:0];
                           depth_d    = depth_q + 7'd1;
                           state_d    = ST_FETCH;
                        end
                     end
                  endcase
               end
            end
            ST_EMIT: begin
               depth_d    = '0;
               cur_addr_d = bus.root_idx;
               state_d    = ST_FETCH;
`ifdef T05_ROOT_CACHE_EN
               if (root_vld_q) begin
                  node_d  = root_q;
                  state_d = ST_WAIT_BIT;
               end
`endif
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cur_addr_q   <= '0;
         depth_q      <= '0;
         node_q       <= '0;
         char_q       <= '0;
         bit_ready_q  <= 1'b0;
         rd_req_q     <= 1'b0;
         rd_addr_q    <= '0;
         char_valid_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_addr_q   <= cur_addr_d;
         depth_q      <= depth_d;
         node_q       <= node_d;
         char_q       <= char_d;
         bit_ready_q  <= (state_d == ST_WAIT_BIT);
         rd_req_q     <= (state_d == ST_FETCH);
         rd_addr_q    <= cur_addr_d;
         char_valid_q <= (state_d == ST_EMIT);
         err_q        <= (state_d == ST_ERROR);
      end
   end

`ifdef T05_ROOT_CACHE_EN
   always_ff @(posedge clk) begin
      if (!rst_n || state_q == ST_IDLE) begin
         root_q     <= '0;
         root_vld_q <= 1'b0;
      end else if (cache_wr) begin
         root_q     <= rd_node;
         root_vld_q <= 1'b1;
      end
   end
`endif

   assign bus.bit_ready  = bit_ready_q;
   assign bus.rd_req     = rd_req_q;
   assign bus.rd_addr    = rd_addr_q;
   assign bus.WorR       = 1'b0;
   assign bus.char_out   = char_q;
   assign bus.char_valid = char_valid_q;
   assign bus.err        = err_q;
   assign bus.state_reg  = state_q;
endmodule

// File: tb/tb_t05_tree_walker.sv
// Directed bench for t05_tree_walker with a 2-cycle-latency SRAM model.
`timescale 1ns/1ps
module tb_t05_tree_walker;
   import t05_huff_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   t05_tree_walker_if bus();

   t05_tree_walker #(.MAX_DEPTH(127)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cv_count = 0;
   logic [7:0]  last_char = '0;
   int unsigned reads = 0;
   int unsigned lat_cnt = 0;
   logic        sram_hold = 1'b0;
   logic [70:0] mem [0:127];

   typedef struct {
      int unsigned nbits;
      logic [1:0]  bits;
      logic [7:0]  exp_char;
   } vec_t;
   vec_t vecs [5];

   function automatic logic [70:0] mk_node(input logic [6:0] idx, input logic [8:0] l,
                                          input logic [8:0] r, input logic [45:0] s);
      return {idx, l, r, s};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // SRAM: completes a request two cycles after rd_req rises, one-cycle finished pulse.
   always @(negedge clk) begin
      if (sram_hold) begin
         bus.SRAM_finished = 1'b0;
      end else if (bus.SRAM_finished) begin
         bus.SRAM_finished = 1'b0;
         lat_cnt = 0;
      end else if (bus.rd_req) begin
         if (lat_cnt == 1) begin
            bus.rd_data       = mem[bus.rd_addr];
            bus.SRAM_finished = 1'b1;
            reads++;
            lat_cnt = 0;
         end else begin
            lat_cnt++;
         end
      end else begin
         lat_cnt = 0;
      end
   end

   always @(negedge clk) begin
      if (bus.char_valid) begin
         cv_count++;
         last_char = bus.char_out;
      end
   end

   task automatic wait_ready();
      int unsigned t = 0;
      while (!bus.bit_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!bus.bit_ready) begin
         checks++;
         errors++;
         $display("FAIL bit_ready_timeout: got 0 expected 1");
      end
   endtask

   task automatic send_bit(input logic b);
      wait_ready();
      bus.bit_in    = b;
      bus.bit_valid = 1'b1;
      @(negedge clk);
      bus.bit_valid = 1'b0;
   endtask

   task automatic decode(input int unsigned nbits, input logic [1:0] bits,
                         input logic [7:0] exp, input string tag);
      int unsigned cv0;
      cv0 = cv_count;
      for (int unsigned i = 0; i < nbits; i++) send_bit(bits[i]);
      @(negedge clk);
      check({tag, "_count"}, 32'(cv_count - cv0), 32'd1);
      check({tag, "_char"}, 32'(last_char), 32'(exp));
      check({tag, "_err"}, 32'(bus.err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [70:0] node0, node1;
      int unsigned exp_reads;
      node0 = mk_node(7'd0, 9'h041, 9'h042, 46'd120);
      node1 = mk_node(7'd1, 9'h043, 9'h100, 46'd200);
      for (int i = 0; i < 128; i++) mem[i] = '0;
      mem[0] = node0;
      mem[1] = node1;
      vecs[0] = '{1, 2'b00, 8'h43};
      vecs[1] = '{2, 2'b01, 8'h41};
      vecs[2] = '{2, 2'b11, 8'h42};
      vecs[3] = '{1, 2'b00, 8'h43};
      vecs[4] = '{2, 2'b01, 8'h41};

      bus.dec_en        = 1'b0;
      bus.root_idx      = 7'd1;
      bus.bit_in        = 1'b0;
      bus.bit_valid     = 1'b0;
      bus.rd_data       = '0;
      bus.SRAM_finished = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_bit_ready", 32'(bus.bit_ready), 32'd0);
      check("rst_rd_req", 32'(bus.rd_req), 32'd0);
      check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
      check("rst_WorR", 32'(bus.WorR), 32'd0);
      check("rst_char_out", 32'(bus.char_out), 32'd0);
      check("rst_char_valid", 32'(bus.char_valid), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_state", 32'(bus.state_reg), 32'd0);
      rst_n = 1'b1;

      bus.dec_en = 1'b1;
      for (int unsigned v = 0; v < 5; v++)
         decode(vecs[v].nbits, vecs[v].bits, vecs[v].exp_char, $sformatf("vec%0d", v));
      check("WorR_run", 32'(bus.WorR), 32'd0);

      // SRAM stalls while fetching node0
      wait_ready();
      sram_hold = 1'b1;
      send_bit(1'b1);
      for (int unsigned c = 0; c < 10; c++) begin
         @(negedge clk);
         check("hold_stable", {28'd0, bus.rd_req, bus.bit_ready, bus.state_reg[1:0]},
               {28'd0, 1'b1, 1'b0, 2'd1});
         check("hold_addr", 32'(bus.rd_addr), 32'd0);
      end
      sram_hold = 1'b0;
      decode(1, 2'b00, 8'h41, "hold_resume");

      // root stored with wrong idx field
      bus.dec_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("idle_state", 32'(bus.state_reg), 32'd0);
      mem[1] = mk_node(7'd5, 9'h043, 9'h100, 46'd200);
      bus.dec_en = 1'b1;
      for (int unsigned t = 0; t < 20 && !bus.err; t++) @(negedge clk);
      check("idx_err", 32'(bus.err), 32'd1);
      check("idx_state", 32'(bus.state_reg), 32'd4);
      check("idx_quiet", {30'd0, bus.rd_req, bus.bit_ready}, 32'd0);
      mem[1] = node1;
      bus.dec_en = 1'b0;
      @(negedge clk);
      check("idx_clr_err", 32'(bus.err), 32'd0);
      check("idx_clr_state", 32'(bus.state_reg), 32'd0);

      // single-leaf tree rooted at node0
      mem[0] = mk_node(7'd0, 9'h05A, CHILD_NULL, 46'd5);
      bus.root_idx = 7'd0;
      bus.dec_en = 1'b1;
      decode(1, 2'b00, 8'h5A, "leaf_Z");
      send_bit(1'b1);
      check("null_err", 32'(bus.err), 32'd1);
      check("null_state", 32'(bus.state_reg), 32'd4);
      bus.dec_en = 1'b0;
      @(negedge clk);
      check("null_clr_err", 32'(bus.err), 32'd0);
      check("null_clr_state", 32'(bus.state_reg), 32'd0);
      mem[0] = node0;
      bus.root_idx = 7'd1;

      // disable mid-walk
      bus.dec_en = 1'b1;
      send_bit(1'b1);
      bus.dec_en = 1'b0;
      @(negedge clk);
      check("drop_state", 32'(bus.state_reg), 32'd0);
      check("drop_rd_req", 32'(bus.rd_req), 32'd0);
      repeat (3) @(negedge clk);
      bus.dec_en = 1'b1;
      decode(1, 2'b00, 8'h43, "drop_resume");

      // root read count for "CCC"
      bus.dec_en = 1'b0;
      repeat (3) @(negedge clk);
      reads = 0;
      bus.dec_en = 1'b1;
      for (int unsigned k = 0; k < 3; k++) decode(1, 2'b00, 8'h43, $sformatf("ccc%0d", k));
`ifdef T05_ROOT_CACHE_EN
      exp_reads = 1;
`else
      exp_reads = 3;
`endif
      check("root_reads", 32'(reads), 32'(exp_reads));

      bus.dec_en = 1'b0;
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
